quadrature_counter: RTL and testbench
=====================================

// Module: quadrature_counter
// PURPOSE
// - Decodes a 2-phase quadrature input pair (a, b) from an encoder into a signed-direction position count.
// - Complements the internal up/down counter: here direction and step rate come from an external source, not a parameter.
// - Sits between the board pins and position/speed consumers; inputs are asynchronous, outputs are clk-domain.
// PARAMETERS
// - SIZE    16  width of value output, bits
// - FILTER  4   consecutive stable clk cycles required before an input change is accepted (>=1)
// - TOP     0   0: value wraps modulo 2^SIZE; nonzero: value range is 0..TOP, wrapping at both ends
// PORTS
// - clk    in   1     clock; single clock domain
// - rst    in   1     synchronous, active-high reset
// - a      in   1     phase A, asynchronous
// - b      in   1     phase B, asynchronous
// - idx    in   1     index pulse, asynchronous (present only with QUAD_INDEX_EN)
// - value  out  SIZE  position count
// - dir    out  1     direction of last accepted step: 1 = up, 0 = down
// - step   out  1     one-cycle pulse per accepted step
// - err    out  1     one-cycle pulse on illegal transition (both phases changed)
// BEHAVIOUR
// - Reset: value=0, dir=0, step=0, err=0; synchronizers and filter cleared; init flag set.
// - Synchronizer: a and b each pass through 2 flops (sa, sb).
// - Filter: per-pair counter. Reload to 0 whenever {sa,sb} differs from previous cycle.
//   When {sa,sb} != filtered state and has held FILTER cycles, adopt it as the new filtered state.
// - Init: the first adoption after reset (init flag set) loads the filtered state only.
//   No step, no err; clears the init flag. The init flag causes the adoption even if {sa,sb} equals the reset value 00.
// - Decode on adoption, old->new filtered {a,b}:
//   - 00->01->11->10->00 is up.
//   - Reverse sequence is down.
//   - Both bits changed: err=1 for one cycle; value and dir unchanged.
// - Step (registered, same edge): step=1 and dir set. value += 1 (up) or -= 1 (down).
// - Wrap with TOP=0: natural modulo 2^SIZE (max+1 -> 0, 0-1 -> all ones).
// - Wrap with TOP!=0: up at TOP -> 0; down at 0 -> TOP. Values above TOP are unreachable.
// - Latency: a clean edge on a/b stable from edge k gives step/value update at edge k+FILTER+3.
// - Pulses shorter than FILTER cycles, after sync, are ignored entirely.
// - Max accepted step rate: one per FILTER+1 cycles; faster input yields err or missed counts (unspecified which).
// - rst asserted mid-operation overrides everything on that edge; the counter restarts from the init state.
// - step and err are never both 1 in the same cycle.
// CONFIGURATION
// - QUAD_INDEX_EN defined:
//   - Port idx exists, with the same 2-flop sync and FILTER qualification.
//   - A qualified rising edge of idx forces value=0 on the next edge.
//   - If a step is accepted on that same edge: value=0 wins; step and dir still update.
// - QUAD_INDEX_EN undefined: no idx port and no index logic; value changes only by steps and reset.
// TESTING
// - Reset, a=b=0, 1 up-cycle (01,11,10,00, each held 10 clks) -> 4 step pulses, dir=1, value=4, err never 1.
// - From value=0, one down step (00->10) -> value=0xFFFF (SIZE=16, TOP=0), dir=0.
// - TOP=9: 10 up steps from 0 -> value 1..9 then 0; one down step from 0 -> value=9.
// - Glitch: a high for FILTER-1 clks after sync, then low -> no step, no err, value unchanged.
// - a and b toggled on the same clk, 00->11 held 10 clks -> single err pulse, value and dir unchanged.
// - QUAD_INDEX_EN: value=7, idx pulse of 10 clks coinciding with an up step -> value=0, step=1, dir=1.

Source files
------------

// File: rtl/quadrature_counter_if.sv
// Quadrature encoder bundle: phase pins toward the decoder, position and
// event pulses back toward the consumer. The idx signal exists only when
// QUAD_INDEX_EN is defined.
interface quadrature_counter_if #(
   parameter int SIZE = 16
) ();
   logic            a;
   logic            b;
`ifdef QUAD_INDEX_EN
   logic            idx;
`endif
   logic [SIZE-1:0] value;
   logic            dir;
   logic            step;
   logic            err;

`ifdef QUAD_INDEX_EN
   modport master (output a, b, idx, input value, dir, step, err);
   modport slave  (input a, b, idx, output value, dir, step, err);
`else
   modport master (output a, b, input value, dir, step, err);
   modport slave  (input a, b, output value, dir, step, err);
`endif
endinterface

// File: rtl/quadrature_counter.sv
// Quadrature decoder: synchronizes asynchronous phase inputs, qualifies each
// new {a,b} state after FILTER stable cycles, and turns accepted Gray-code
// transitions into up/down position steps or an illegal-transition pulse.
// Optional macro QUAD_INDEX_EN adds a filtered index input whose rising edge
// clears the position.
module quadrature_counter #(
   parameter int SIZE   = 16,
   parameter int FILTER = 4,
   parameter int TOP    = 0
) (
   input logic              clk,
   input logic              rst,
   quadrature_counter_if.slave bus
);

   localparam int              CW       = $clog2(FILTER + 1);
   localparam logic [CW-1:0]   FILT_MAX = CW'(FILTER);
   localparam logic [SIZE-1:0] TOP_V    = SIZE'(TOP);

   // Gray position of a phase pair: 00->0, 01->1, 11->2, 10->3
   function automatic logic [1:0] gray2bin(input logic [1:0] g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   // Quarter-turn distance old->new: 1 = up, 3 = down, 2 = both phases changed
   function automatic logic [1:0] gray_delta(input logic [1:0] old_ab, input logic [1:0] new_ab);
      return gray2bin(new_ab) - gray2bin(old_ab);
   endfunction

   // Next position with wrap either modulo 2^SIZE or across 0..TOP
   function automatic logic [SIZE-1:0] next_value(input logic [SIZE-1:0] v, input logic up);
      logic [SIZE-1:0] r;
      if (TOP == 0) begin
         r = up ? v + SIZE'(1) : v - SIZE'(1);
      end else if (up) begin
         r = (v == TOP_V) ? '0 : v + SIZE'(1);
      end else begin
         r = (v == '0) ? TOP_V : v - SIZE'(1);
      end
      return r;
   endfunction

   logic [1:0]      sync_p0;   // first synchronizer stage
   logic [1:0]      sync_p1;   // {sa,sb}
   logic [1:0]      hist_p2;   // {sa,sb} one cycle earlier
   logic [CW-1:0]   cnt;       // cycles hist_p2 has been stable
   logic [1:0]      filt;      // accepted phase state
   logic            init;
   logic            adopt;
   logic            idx_rise;

   logic [SIZE-1:0] val_q, val_nxt;
   logic            dir_q, dir_nxt;
   logic            step_q, step_nxt;
   logic            err_q, err_nxt;

   // --- stage p0/p1: two-flop synchronizer for both phases
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 2'b00;
         sync_p1 <= 2'b00;
      end else begin
         sync_p0 <= {bus.a, bus.b};
         sync_p1 <= sync_p0;
      end
   end

   // --- stage p2: stability counter; reloads whenever the synced pair moves
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_p2 <= 2'b00;
         cnt     <= '0;
         filt    <= 2'b00;
         init    <= 1'b1;
      end else begin
         hist_p2 <= sync_p1;
         if (sync_p1 != hist_p2) begin
            cnt <= '0;
         end else if (cnt != FILT_MAX) begin
            cnt <= cnt + CW'(1);
         end
         if (adopt) begin
            filt <= hist_p2;
            init <= 1'b0;
         end
      end
   end

   // The init flag forces the first adoption even when the pair still reads 00
   assign adopt = (sync_p1 == hist_p2) && (cnt == FILT_MAX) && (init || (hist_p2 != filt));

`ifdef QUAD_INDEX_EN
   logic          idx_p0, idx_p1, idx_hist_p2, idx_filt;
   logic [CW-1:0] idx_cnt;
   logic          idx_adopt;

   // Index path: same synchronizer and stability qualification as the phases
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_p0      <= 1'b0;
         idx_p1      <= 1'b0;
         idx_hist_p2 <= 1'b0;
         idx_cnt     <= '0;
         idx_filt    <= 1'b0;
      end else begin
         idx_p0      <= bus.idx;
         idx_p1      <= idx_p0;
         idx_hist_p2 <= idx_p1;
         if (idx_p1 != idx_hist_p2) begin
            idx_cnt <= '0;
         end else if (idx_cnt != FILT_MAX) begin
            idx_cnt <= idx_cnt + CW'(1);
         end
         if (idx_adopt) begin
            idx_filt <= idx_hist_p2;
         end
      end
   end

   assign idx_adopt = (idx_p1 == idx_hist_p2) && (idx_cnt == FILT_MAX) && (idx_hist_p2 != idx_filt);
   assign idx_rise  = idx_adopt && idx_hist_p2;
`else
   assign idx_rise  = 1'b0;
`endif

   // Decode the accepted transition; an index clear overrides any step value
   always_comb begin
      step_nxt = 1'b0;
      err_nxt  = 1'b0;
      dir_nxt  = dir_q;
      val_nxt  = val_q;
      if (adopt && !init) begin
         case (gray_delta(filt, hist_p2))
            2'd1: begin
               step_nxt = 1'b1;
               dir_nxt  = 1'b1;
               val_nxt  = next_value(val_q, 1'b1);
            end
            2'd3: begin
               step_nxt = 1'b1;
               dir_nxt  = 1'b0;
               val_nxt  = next_value(val_q, 1'b0);
            end
            2'd2:    err_nxt = 1'b1;
            default: ;
         endcase
      end
      if (idx_rise) begin
         val_nxt = '0;
      end
   end

   // --- stage p3: registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         val_q  <= '0;
         dir_q  <= 1'b0;
         step_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         val_q  <= val_nxt;
         dir_q  <= dir_nxt;
         step_q <= step_nxt;
         err_q  <= err_nxt;
      end
   end

   assign bus.value = val_q;
   assign bus.dir   = dir_q;
   assign bus.step  = step_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_quadrature_counter.sv
// Directed bench for quadrature_counter: one modulo-2^16 instance and one
// TOP=9 instance, both FILTER=4, driven with identical phase stimulus.
// Index scenario is compiled in when QUAD_INDEX_EN is defined.
module tb_quadrature_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   int steps0 = 0, errs0 = 0, steps9 = 0, errs9 = 0, both_cnt = 0;

   quadrature_counter_if #(.SIZE(16)) q0 ();
   quadrature_counter_if #(.SIZE(16)) q9 ();

   quadrature_counter #(.SIZE(16), .FILTER(4), .TOP(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (q0)
   );

   quadrature_counter #(.SIZE(16), .FILTER(4), .TOP(9)) dut9 (
      .clk (clk),
      .rst (rst),
      .bus (q9)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (q0.step) steps0 <= steps0 + 1;
      if (q0.err)  errs0  <= errs0 + 1;
      if (q9.step) steps9 <= steps9 + 1;
      if (q9.err)  errs9  <= errs9 + 1;
      if ((q0.step && q0.err) || (q9.step && q9.err)) both_cnt <= both_cnt + 1;
   end

   // Drive {a,b} on both instances just after an edge, then hold n cycles
   task automatic drive_ab(input logic [1:0] ab, input int n);
      q0.a = ab[1];
      q0.b = ab[0];
      q9.a = ab[1];
      q9.b = ab[0];
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_ab(2'b00, 3);
      rst = 1'b0;
      drive_ab(2'b00, 10);
   endtask

   task automatic test_reset();
      int s0, e0;
      rst = 1'b1;
      drive_ab(2'b00, 3);
      tests++; if (q0.value !== 16'h0000) begin fails++; $display("FAIL reset_value got=%h exp=0000", q0.value); end
      tests++; if (q0.dir !== 1'b0) begin fails++; $display("FAIL reset_dir got=%b exp=0", q0.dir); end
      tests++; if (q0.step !== 1'b0) begin fails++; $display("FAIL reset_step got=%b exp=0", q0.step); end
      tests++; if (q0.err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", q0.err); end
      tests++; if (q9.value !== 16'h0000) begin fails++; $display("FAIL reset_value9 got=%h exp=0000", q9.value); end
      s0 = steps0; e0 = errs0;
      rst = 1'b0;
      drive_ab(2'b00, 10);
      tests++; if (steps0 - s0 !== 0) begin fails++; $display("FAIL init_step got=%0d exp=0", steps0 - s0); end
      tests++; if (errs0 - e0 !== 0) begin fails++; $display("FAIL init_err got=%0d exp=0", errs0 - e0); end
   endtask

   task automatic test_latency();
      do_reset();
      q0.a = 1'b0; q0.b = 1'b1;
      q9.a = 1'b0; q9.b = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      tests++; if (q0.step !== 1'b0 || q0.value !== 16'h0000) begin fails++; $display("FAIL latency_early step=%b value=%h exp step=0 value=0000", q0.step, q0.value); end
      @(posedge clk);
      #1;
      tests++; if (q0.step !== 1'b1) begin fails++; $display("FAIL latency_step got=%b exp=1", q0.step); end
      tests++; if (q0.value !== 16'h0001) begin fails++; $display("FAIL latency_value got=%h exp=0001", q0.value); end
      tests++; if (q0.dir !== 1'b1) begin fails++; $display("FAIL latency_dir got=%b exp=1", q0.dir); end
      @(posedge clk);
      #1;
      tests++; if (q0.step !== 1'b0) begin fails++; $display("FAIL latency_pulse got=%b exp=0", q0.step); end
   endtask

   task automatic test_up_cycle();
      logic [1:0] seq [4];
      int s0, e0;
      seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
      do_reset();
      s0 = steps0; e0 = errs0;
      for (int i = 0; i < 4; i++) begin
         drive_ab(seq[i], 10);
         tests++; if (q0.value !== 16'(i + 1)) begin fails++; $display("FAIL up_value[%0d] got=%h exp=%h", i, q0.value, 16'(i + 1)); end
         tests++; if (q0.dir !== 1'b1) begin fails++; $display("FAIL up_dir[%0d] got=%b exp=1", i, q0.dir); end
      end
      tests++; if (steps0 - s0 !== 4) begin fails++; $display("FAIL up_steps got=%0d exp=4", steps0 - s0); end
      tests++; if (errs0 - e0 !== 0) begin fails++; $display("FAIL up_err got=%0d exp=0", errs0 - e0); end
   endtask

   task automatic test_down_wrap();
      do_reset();
      drive_ab(2'b10, 10);
      tests++; if (q0.value !== 16'hFFFF) begin fails++; $display("FAIL down_wrap got=%h exp=ffff", q0.value); end
      tests++; if (q0.dir !== 1'b0) begin fails++; $display("FAIL down_dir got=%b exp=0", q0.dir); end
      tests++; if (q9.value !== 16'd9) begin fails++; $display("FAIL down_wrap9 got=%0d exp=9", q9.value); end
   endtask

   task automatic test_top9();
      logic [1:0] seq [4];
      int s9;
      seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
      do_reset();
      s9 = steps9;
      for (int i = 0; i < 10; i++) begin
         drive_ab(seq[i % 4], 10);
         tests++; if (q9.value !== 16'((i + 1) % 10)) begin fails++; $display("FAIL top9_value[%0d] got=%0d exp=%0d", i, q9.value, (i + 1) % 10); end
      end
      tests++; if (steps9 - s9 !== 10) begin fails++; $display("FAIL top9_steps got=%0d exp=10", steps9 - s9); end
      drive_ab(2'b01, 10);
      tests++; if (q9.value !== 16'd9) begin fails++; $display("FAIL top9_down got=%0d exp=9", q9.value); end
      tests++; if (q0.value !== 16'd9) begin fails++; $display("FAIL top0_down got=%0d exp=9", q0.value); end
   endtask

   task automatic test_glitch();
      int s0, e0;
      do_reset();
      s0 = steps0; e0 = errs0;
      drive_ab(2'b10, 3);
      drive_ab(2'b00, 10);
      tests++; if (steps0 - s0 !== 0) begin fails++; $display("FAIL glitch_step got=%0d exp=0", steps0 - s0); end
      tests++; if (errs0 - e0 !== 0) begin fails++; $display("FAIL glitch_err got=%0d exp=0", errs0 - e0); end
      tests++; if (q0.value !== 16'h0000) begin fails++; $display("FAIL glitch_value got=%h exp=0000", q0.value); end
   endtask

   task automatic test_illegal();
      int s0, e0;
      do_reset();
      s0 = steps0; e0 = errs0;
      drive_ab(2'b11, 10);
      tests++; if (errs0 - e0 !== 1) begin fails++; $display("FAIL illegal_err got=%0d exp=1", errs0 - e0); end
      tests++; if (steps0 - s0 !== 0) begin fails++; $display("FAIL illegal_step got=%0d exp=0", steps0 - s0); end
      tests++; if (q0.value !== 16'h0000) begin fails++; $display("FAIL illegal_value got=%h exp=0000", q0.value); end
      tests++; if (q0.dir !== 1'b0) begin fails++; $display("FAIL illegal_dir got=%b exp=0", q0.dir); end
   endtask

`ifdef QUAD_INDEX_EN
   task automatic test_index();
      logic [1:0] seq [4];
      int s0;
      seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
      do_reset();
      for (int i = 0; i < 7; i++) drive_ab(seq[i % 4], 10);
      tests++; if (q0.value !== 16'd7) begin fails++; $display("FAIL index_pre got=%0d exp=7", q0.value); end
      s0 = steps0;
      q0.idx = 1'b1;
      q9.idx = 1'b1;
      drive_ab(2'b00, 10);
      tests++; if (q0.value !== 16'd0) begin fails++; $display("FAIL index_value got=%0d exp=0", q0.value); end
      tests++; if (steps0 - s0 !== 1) begin fails++; $display("FAIL index_step got=%0d exp=1", steps0 - s0); end
      tests++; if (q0.dir !== 1'b1) begin fails++; $display("FAIL index_dir got=%b exp=1", q0.dir); end
      q0.idx = 1'b0;
      q9.idx = 1'b0;
      drive_ab(2'b00, 10);
      tests++; if (q0.value !== 16'd0) begin fails++; $display("FAIL index_fall got=%0d exp=0", q0.value); end
   endtask
`endif

   task automatic test_exclusive();
      tests++; if (both_cnt !== 0) begin fails++; $display("FAIL step_err_overlap got=%0d exp=0", both_cnt); end
   endtask

   initial begin
`ifdef QUAD_INDEX_EN
      q0.idx = 1'b0;
      q9.idx = 1'b0;
`endif
      test_reset();
      test_latency();
      test_up_cycle();
      test_down_wrap();
      test_top9();
      test_glitch();
      test_illegal();
`ifdef QUAD_INDEX_EN
      test_index();
`endif
      test_exclusive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
